hp_lcd_vga_timing_regen: RTL

//  Parametrised successor of the HP54542C LCD-to-VGA converter. Locks onto the scope's LCD frame
//  via the composite iw_sync line and regenerates VGA hsync, vsync and data-enable from

---
 rtl/hp_lcd_vga_timing_regen_if.sv | 24 ++
 rtl/hp_lcd_vga_timing_regen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hp_lcd_vga_timing_regen_if.sv
// LCD tap / VGA side signal bundle for the HP LCD-to-VGA timing regenerator.
// The master drives the LCD tap side; the regenerator sits on the slave modport.
interface hp_lcd_vga_timing_regen_if #(
  parameter int unsigned P_BPC = 1
);
  logic                 iw_sync;
  logic [3*P_BPC-1:0]   iw_rgb;
  logic [3*P_BPC-1:0]   ow_rgb;
  logic                 ow_hsync;
  logic                 ow_vsync;
  logic                 ow_de;
  logic                 ow_locked;
  logic [7:0]           ow_frame_err;

  modport master (
    output iw_sync, iw_rgb,
    input  ow_rgb, ow_hsync, ow_vsync, ow_de, ow_locked, ow_frame_err
  );

  modport slave (
    input  iw_sync, iw_rgb,
    output ow_rgb, ow_hsync, ow_vsync, ow_de, ow_locked, ow_frame_err
  );
endinterface

// File: rtl/hp_lcd_vga_timing_regen.sv
// Locks onto the HP54542C LCD frame via the composite sync line and regenerates
// VGA hsync/vsync/de from parametrised timing, with lock-loss and frame-error tracking.
module hp_lcd_vga_timing_regen #(
  parameter int unsigned P_BPC       = 1,
  parameter int unsigned P_H_ACTIVE  = 640,
  parameter int unsigned P_HFP       = 16,
  parameter int unsigned P_HSP       = 96,
  parameter int unsigned P_HBP       = 48,
  parameter int unsigned P_V_ACTIVE  = 480,
  parameter int unsigned P_VFP       = 10,
  parameter int unsigned P_VSP       = 2,
  parameter int unsigned P_VBP       = 33,
  parameter int unsigned P_GAP_MIN   = 1000,
  parameter int unsigned P_LOCK_TOL  = 64,
  parameter int unsigned P_HSYNC_POL = 0,
  parameter int unsigned P_VSYNC_POL = 0
) (
  input  logic iw_clk,
  input  logic iw_reset,
  hp_lcd_vga_timing_regen_if.slave bus
);
  localparam int unsigned H_TOTAL  = P_H_ACTIVE + P_HFP + P_HSP + P_HBP;
  localparam int unsigned V_TOTAL  = P_V_ACTIVE + P_VFP + P_VSP + P_VBP;
  localparam int unsigned F_TOTAL  = H_TOTAL * V_TOTAL;
  localparam int unsigned WD_LIMIT = F_TOTAL + P_LOCK_TOL;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);
  localparam int unsigned GAP_W    = $clog2(P_GAP_MIN + 1);
  localparam int unsigned H_W      = $clog2(H_TOTAL + 1);
  localparam int unsigned V_W      = $clog2(V_TOTAL + 1);
  localparam int unsigned RGB_W    = 3 * P_BPC;

  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(P_GAP_MIN);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WD_LIMIT);
  localparam logic [WD_W:0]    WIN_LO  = (WD_W+1)'(F_TOTAL - P_LOCK_TOL);
  localparam logic [WD_W:0]    WIN_HI  = (WD_W+1)'(F_TOTAL + P_LOCK_TOL);
  localparam logic [H_W-1:0]   H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT   = H_W'(P_H_ACTIVE);
  localparam logic [H_W-1:0]   HS_BEG  = H_W'(P_H_ACTIVE + P_HFP);
  localparam logic [H_W-1:0]   HS_END  = H_W'(P_H_ACTIVE + P_HFP + P_HSP);
  localparam logic [V_W-1:0]   V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT   = V_W'(P_V_ACTIVE);
  localparam logic [V_W-1:0]   VS_BEG  = V_W'(P_V_ACTIVE + P_VFP);
  localparam logic [V_W-1:0]   VS_END  = V_W'(P_V_ACTIVE + P_VFP + P_VSP);
  localparam logic             HS_ON   = (P_HSYNC_POL != 0);
  localparam logic             VS_ON   = (P_VSYNC_POL != 0);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state, state_n;
  logic              sync_meta, sync_q, sync_prev, fs;
  logic [GAP_W-1:0]  gap;
  logic [RGB_W-1:0]  rgb_dly [4];
  logic [H_W-1:0]    h, h_n;
  logic [V_W-1:0]    v, v_n;
  logic [WD_W-1:0]   wd, wd_n;
  logic [WD_W:0]     wd_inc;
  logic [7:0]        err, err_n, err_inc;
  logic              locked, in_window;
  logic              de_n, hs_act, vs_act;
  logic              de_q, hs_q, vs_q;
  logic [RGB_W-1:0]  rgb_q;

  // Synchroniser, edge detect and frame-start qualification. The pixel delay is one
  // stage deeper than the sync path so the FS pixel lands with the first de cycle.
  always_ff @(posedge iw_clk) begin
    if (iw_reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
      gap       <= '0;
      fs        <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) rgb_dly[i] <= '0;
    end else begin
      sync_meta <= bus.iw_sync;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
      if (sync_q)            gap <= '0;
      else if (gap != GAP_MAX) gap <= gap + GAP_W'(1);
      fs         <= sync_q && !sync_prev && (gap == GAP_MAX);
      rgb_dly[0] <= bus.iw_rgb;
      for (int unsigned i = 1; i < 4; i++) rgb_dly[i] <= rgb_dly[i-1];
    end
  end

  assign locked    = (state == LOCKED);
  assign wd_inc    = {1'b0, wd} + (WD_W+1)'(1);
  assign in_window = (wd_inc >= WIN_LO) && (wd_inc <= WIN_HI);
  assign err_inc   = (err == 8'hFF) ? err : err + 8'd1;

  always_ff @(posedge iw_clk) begin
    if (iw_reset) begin
      state <= SEARCH;
      h     <= '0;
      v     <= '0;
      wd    <= '0;
      err   <= '0;
    end else begin
      state <= state_n;
      h     <= h_n;
      v     <= v_n;
      wd    <= wd_n;
      err   <= err_n;
    end
  end

  // A frame start takes priority over watchdog expiry in the same cycle.
  always_comb begin
    state_n = state;
    h_n     = h;
    v_n     = v;
    wd_n    = wd;
    err_n   = err;
    unique case (state)
      SEARCH: begin
        if (fs) begin
          state_n = LOCKED;
          h_n     = '0;
          v_n     = '0;
          wd_n    = '0;
        end
      end
      LOCKED: begin
        if (fs) begin
          h_n  = '0;
          v_n  = '0;
          wd_n = '0;
          if (!in_window) err_n = err_inc;
        end else if (wd == WD_MAX) begin
          state_n = SEARCH;
          h_n     = '0;
          v_n     = '0;
          wd_n    = '0;
          err_n   = err_inc;
        end else begin
          wd_n = wd + WD_W'(1);
          if (h == H_LAST) begin
            h_n = '0;
            v_n = (v == V_LAST) ? '0 : v + V_W'(1);
          end else begin
            h_n = h + H_W'(1);
          end
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_comb begin
    de_n   = locked && (h < H_ACT) && (v < V_ACT);
    hs_act = locked && (h >= HS_BEG) && (h < HS_END);
    vs_act = locked && (v >= VS_BEG) && (v < VS_END);
  end

  always_ff @(posedge iw_clk) begin
    if (iw_reset) begin
      de_q  <= 1'b0;
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      rgb_q <= '0;
    end else begin
      de_q  <= de_n;
      hs_q  <= hs_act ? HS_ON : ~HS_ON;
      vs_q  <= vs_act ? VS_ON : ~VS_ON;
      rgb_q <= de_n ? rgb_dly[3] : '0;
    end
  end

  assign bus.ow_rgb       = rgb_q;
  assign bus.ow_hsync     = hs_q;
  assign bus.ow_vsync     = vs_q;
  assign bus.ow_de        = de_q;
  assign bus.ow_locked    = locked;
  assign bus.ow_frame_err = err;
endmodule
